// File: rtl/snowv_session_arbiter_if.sv
// snowv_session_arbiter_if: requester, SNOW_V core and keystream signals of the session arbiter
interface snowv_session_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
);
  logic [NUM_REQ-1:0]     req;
  logic [NUM_REQ*256-1:0] key_in;
  logic [NUM_REQ*128-1:0] iv_in;
  logic [NUM_REQ*64-1:0]  len_in;
  logic [NUM_REQ-1:0]     gnt;
  logic [NUM_REQ-1:0]     done;
  logic [NUM_REQ-1:0]     err;
  logic                   busy;
  logic [255:0]           core_key;
  logic [127:0]           core_iv;
  logic [63:0]            core_length;
  logic                   core_start;
  logic                   core_valid;
  logic [255:0]           core_z;
  logic                   ks_valid;
  logic [255:0]           ks_data;
  logic [ID_W-1:0]        ks_id;
  logic                   ks_last;
  modport master (
    output req, key_in, iv_in, len_in, core_valid, core_z,
    input  gnt, done, err, busy, core_key, core_iv, core_length, core_start,
           ks_valid, ks_data, ks_id, ks_last
  );
  modport slave (
    input  req, key_in, iv_in, len_in, core_valid, core_z,
    output gnt, done, err, busy, core_key, core_iv, core_length, core_start,
           ks_valid, ks_data, ks_id, ks_last
  );
endinterface

// File: rtl/snowv_session_arbiter.sv
// snowv_session_arbiter: round-robin sharing of one SNOW_V keystream core between NUM_REQ requesters
// Optional stall watchdog is enabled by defining SNOWV_ARB_TIMEOUT_EN.
module snowv_session_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int TIMEOUT = 1024
) (
  input logic               clk,
  input logic               rst_n,
  snowv_session_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, LAUNCH, STREAM, DONE} state_t;
  if (ID_W != $clog2(NUM_REQ)) $error("ID_W must equal clog2(NUM_REQ)");
  if (TIMEOUT < 2) $error("TIMEOUT must be at least 2");
  state_t state, state_nx;
  logic [ID_W-1:0] rr_ptr, id, sel, idx;
  logic [NUM_REQ-1:0] onehot;
  logic [63:0] sel_len;
  logic [58:0] sel_words, words, cnt;
  logic hit, last, to_hit;
  // first requester at or above rr_ptr, wrapping; lowest offset wins
  always_comb begin
    sel = rr_ptr;
    idx = rr_ptr;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
      if (bus.req[idx]) sel = idx;
    end
  end
  assign sel_len   = bus.len_in[sel*64 +: 64];
  assign sel_words = sel_len[63:5] + 59'(|sel_len[4:0]);
  assign hit       = state == STREAM && bus.core_valid;
  assign last      = cnt + 59'd1 == words;
  assign onehot    = NUM_REQ'(1) << id;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = |bus.req ? (sel_words == '0 ? DONE : LAUNCH) : IDLE;
      LAUNCH:  state_nx = STREAM;
      STREAM:  state_nx = (hit && last) || to_hit ? DONE : STREAM;
      default: state_nx = IDLE;
    endcase
  end
  assign bus.gnt        = state == LAUNCH || state == STREAM ? onehot : '0;
  assign bus.done       = state == DONE ? onehot : '0;
  assign bus.busy       = state != IDLE;
  assign bus.core_start = state == LAUNCH;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state           <= IDLE;
      rr_ptr          <= '0;
      id              <= '0;
      words           <= '0;
      cnt             <= '0;
      bus.core_key    <= '0;
      bus.core_iv     <= '0;
      bus.core_length <= '0;
      bus.ks_valid    <= 1'b0;
      bus.ks_last     <= 1'b0;
      bus.ks_data     <= '0;
      bus.ks_id       <= '0;
    end else begin
      state        <= state_nx;
      bus.ks_valid <= hit;
      bus.ks_last  <= hit && last;
      if (hit) begin
        bus.ks_data <= bus.core_z;
        bus.ks_id   <= id;
        cnt         <= cnt + 59'd1;
      end
      if (state == IDLE && |bus.req) begin
        id              <= sel;
        words           <= sel_words;
        cnt             <= '0;
        bus.core_key    <= bus.key_in[sel*256 +: 256];
        bus.core_iv     <= bus.iv_in[sel*128 +: 128];
        bus.core_length <= sel_len;
      end
      if (state == DONE) rr_ptr <= id == ID_W'(NUM_REQ - 1) ? '0 : id + ID_W'(1);
    end
  end
`ifdef SNOWV_ARB_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT);
  logic [WD_W-1:0] wd;
  logic to_flag;
  // cleared during LAUNCH so STREAM always starts from zero
  assign to_hit  = state == STREAM && !bus.core_valid && wd == WD_W'(TIMEOUT - 1);
  assign bus.err = state == DONE && to_flag ? onehot : '0;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wd      <= '0;
      to_flag <= 1'b0;
    end else begin
      wd      <= state != STREAM || bus.core_valid ? '0 : wd + WD_W'(1);
      to_flag <= to_hit;
    end
  end
`else
  assign to_hit  = 1'b0;
  assign bus.err = '0;
`endif
endmodule

// File: tb/tb_snowv_session_arbiter.sv
// tb_snowv_session_arbiter: directed and randomized sessions checked against a session-level model
`timescale 1ns/1ps
module tb_snowv_session_arbiter;
  localparam int N = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  snowv_session_arbiter_if #(.NUM_REQ(N), .ID_W(2)) bus ();
  snowv_session_arbiter #(.NUM_REQ(N), .ID_W(2), .TIMEOUT(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  int n_cmp = 0;
  int n_bad = 0;
  logic [255:0] m_key [N];
  logic [127:0] m_iv [N];
  logic [63:0]  m_len [N];
  logic [3:0]   rq = '0;
  logic [3:0]   nb;
  logic [255:0] z;
  int m_rr = 0;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      bus.key_in[i*256 +: 256] = m_key[i];
      bus.iv_in[i*128 +: 128]  = m_iv[i];
      bus.len_in[i*64 +: 64]   = m_len[i];
    end
    bus.req = rq;
  endtask

  task automatic newreq(input int i, input int len);
    m_key[i] = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    m_iv[i]  = {$urandom, $urandom, $urandom, $urandom};
    m_len[i] = 64'(len);
    rq = rq | 4'(1 << i);
    drive();
  endtask

  function automatic logic [255:0] rnd256();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  // round-robin winner: first requesting index at or after rr, wrapping
  function automatic int pick(input logic [3:0] r, input int rr);
    for (int k = 0; k < N; k++)
      if (((r >> ((rr + k) % N)) & 4'd1) != 4'd0) return (rr + k) % N;
    return 0;
  endfunction

  task automatic chk_zero(input string tag);
    chk({tag, "_gnt"}, bus.gnt, 0);
    chk({tag, "_done"}, bus.done, 0);
    chk({tag, "_err"}, bus.err, 0);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_start"}, bus.core_start, 0);
    chk({tag, "_key"}, bus.core_key, 0);
    chk({tag, "_iv"}, bus.core_iv, 0);
    chk({tag, "_len"}, bus.core_length, 0);
    chk({tag, "_ksv"}, bus.ks_valid, 0);
    chk({tag, "_ksd"}, bus.ks_data, 0);
    chk({tag, "_ksid"}, bus.ks_id, 0);
    chk({tag, "_ksl"}, bus.ks_last, 0);
  endtask

  // entered in an IDLE cycle with rq already driven; returns in the following IDLE cycle
  task automatic serve(input int gap_max, input logic raise);
    int id, words;
    logic [3:0] oh;
    logic [255:0] zz;
    id = pick(rq, m_rr);
    oh = 4'(1 << id);
    words = int'((m_len[id] + 64'd31) / 64'd32);
    tick();
    if (words == 0) begin
      chk("zl_done", bus.done, oh);
      chk("zl_busy", bus.busy, 1);
      chk("zl_start", bus.core_start, 0);
      chk("zl_gnt", bus.gnt, 0);
      chk("zl_ksv", bus.ks_valid, 0);
    end else begin
      chk("l_gnt", bus.gnt, oh);
      chk("l_start", bus.core_start, 1);
      chk("l_done", bus.done, 0);
      chk("l_key", bus.core_key, m_key[id]);
      chk("l_iv", bus.core_iv, m_iv[id]);
      chk("l_len", bus.core_length, m_len[id]);
      bus.core_valid = 1'b1;
      bus.core_z = rnd256();
      if (raise) begin
        nb = 4'($urandom) & ~rq;
        for (int i = 0; i < N; i++) if (nb[i]) newreq(i, int'($urandom_range(0, 140)));
      end
      tick();
      chk("launch_valid_ignored", bus.ks_valid, 0);
      chk("s_start", bus.core_start, 0);
      for (int w = 0; w < words; w++) begin
        for (int g = int'($urandom_range(0, gap_max)); g > 0; g--) begin
          bus.core_valid = 1'b0;
          tick();
          chk("gap_ksv", bus.ks_valid, 0);
          chk("gap_gnt", bus.gnt, oh);
        end
        zz = rnd256();
        bus.core_valid = 1'b1;
        bus.core_z = zz;
        tick();
        chk("ks_valid", bus.ks_valid, 1);
        chk("ks_data", bus.ks_data, zz);
        chk("ks_id", bus.ks_id, id);
        chk("ks_last", bus.ks_last, w == words - 1);
        chk("s_done", bus.done, w == words - 1 ? oh : 4'd0);
        chk("s_gnt", bus.gnt, w == words - 1 ? 4'd0 : oh);
        chk("s_err", bus.err, 0);
      end
    end
    rq = rq & ~oh;
    drive();
    bus.core_valid = 1'b1;
    bus.core_z = rnd256();
    m_rr = (id + 1) % N;
    tick();
    chk("post_ksv", bus.ks_valid, 0);
    chk("post_done", bus.done, 0);
    chk("post_gnt", bus.gnt, 0);
    chk("post_busy", bus.busy, 0);
    bus.core_valid = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      m_key[i] = '0;
      m_iv[i] = '0;
      m_len[i] = '0;
    end
    drive();
    bus.core_valid = 1'b0;
    bus.core_z = '0;
    repeat (2) tick();
    chk_zero("reset");
    rst_n = 1'b1;
    // single 32-byte session, all-ones key/iv
    m_key[0] = '1;
    m_iv[0] = '1;
    m_len[0] = 64'd32;
    rq = 4'b0001;
    drive();
    serve(0, 1'b0);
    // two contenders, then wrap from rr_ptr=3
    newreq(0, 64);
    newreq(2, 64);
    serve(1, 1'b0);
    serve(1, 1'b0);
    newreq(0, 64);
    newreq(1, 64);
    serve(0, 1'b0);
    serve(0, 1'b0);
    // zero length
    newreq(1, 0);
    serve(0, 1'b0);
    // reset mid-STREAM of a 4-word session
    newreq(2, 128);
    tick();
    chk("r_gnt", bus.gnt, 4'b0100);
    bus.core_valid = 1'b0;
    tick();
    repeat (2) begin
      z = rnd256();
      bus.core_valid = 1'b1;
      bus.core_z = z;
      tick();
      chk("r_ksd", bus.ks_data, z);
    end
    rst_n = 1'b0;
    tick();
    chk_zero("reset_mid");
    rst_n = 1'b1;
    rq = '0;
    drive();
    repeat (3) begin
      tick();
      chk("r_valid_ignored", bus.ks_valid, 0);
      chk("r_no_done", bus.done, 0);
      chk("r_busy", bus.busy, 0);
    end
    bus.core_valid = 1'b0;
    m_rr = 0;
    newreq(1, 40);
    newreq(3, 20);
    serve(0, 1'b0);
    serve(0, 1'b0);
    // 33 bytes: two words, stray valid after DONE
    newreq(3, 33);
    serve(0, 1'b0);
    // stalled core
    newreq(0, 256);
    tick();
    chk("t_start", bus.core_start, 1);
    bus.core_valid = 1'b0;
    tick();
`ifdef SNOWV_ARB_TIMEOUT_EN
    for (int k = 1; k < 16; k++) begin
      tick();
      chk("t_wait_done", bus.done, 0);
      chk("t_wait_err", bus.err, 0);
    end
    tick();
    chk("t_err", bus.err, 4'b0001);
    chk("t_done", bus.done, 4'b0001);
    chk("t_ksl", bus.ks_last, 0);
    rq = '0;
    drive();
    m_rr = 1;
    tick();
    chk("t_idle", bus.busy, 0);
`else
    for (int k = 0; k < 100; k++) begin
      tick();
      chk("t_busy", bus.busy, 1);
      chk("t_nodone", bus.done, 0);
    end
    rq = '0;
    drive();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    m_rr = 0;
    chk("t_reset_busy", bus.busy, 0);
`endif
    // randomized traffic, requests also rising while busy
    for (int it = 0; it < 25; it++) begin
      nb = 4'($urandom) & ~rq;
      for (int i = 0; i < N; i++) if (nb[i]) newreq(i, int'($urandom_range(0, 140)));
      if (rq == '0) newreq(int'($urandom_range(0, 3)), int'($urandom_range(0, 140)));
      serve(2, 1'b1);
    end
    while (rq != '0) serve(1, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
